regfile_write_arbiter: RTL and testbench

Shares the single write port of the physical register file between several writeback sources and, optionally, sequences a post-reset clear of the register file. It sits between the writeback units and the register bank. It drives the bank's `write_addr`/`new_data`/`commit` inputs from one registered stage. Writes to physical register 0 never reach the bank.

---
 rtl/regfile_write_arbiter_if.sv | 15 +
 rtl/regfile_write_arbiter.sv | 130 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bundle between the writeback units (master) and the
// register-file write arbiter (slave).
interface regfile_write_arbiter_if #(
  parameter int unsigned NUM_WB_PORTS = 3,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_W       = 6
);
  logic [NUM_WB_PORTS-1:0]                 wb_valid;
  logic [NUM_WB_PORTS-1:0][ADDR_W-1:0]     wb_addr;
  logic [NUM_WB_PORTS-1:0][DATA_WIDTH-1:0] wb_data;
  logic [NUM_WB_PORTS-1:0]                 wb_ack;

  modport master (output wb_valid, wb_addr, wb_data, input wb_ack);
  modport slave  (input wb_valid, wb_addr, wb_data, output wb_ack);
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the physical register file write port, with an optional
// post-reset clear sweep of registers 1..DEPTH-1 enabled by REGFILE_INIT_CLEAR_EN.
module regfile_write_arbiter #(
  parameter int unsigned NUM_WB_PORTS = 3,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned ADDR_W       = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_write_arbiter_if.slave wb,
  output logic [ADDR_W-1:0]     write_addr,
  output logic [DATA_WIDTH-1:0] new_data,
  output logic                  commit,
  output logic                  init_done
);

  localparam int unsigned PTR_W = (NUM_WB_PORTS > 1) ? $clog2(NUM_WB_PORTS) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

`ifdef REGFILE_INIT_CLEAR_EN
  localparam state_t RESET_STATE = ST_INIT;
`else
  localparam state_t RESET_STATE = ST_RUN;
`endif

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [PTR_W-1:0]        winner;
  logic [PTR_W-1:0]        idx_p;
  logic                    found;
  int unsigned             idx;
  logic [NUM_WB_PORTS-1:0] ack_c;

  logic                    commit_q, commit_d;
  logic [ADDR_W-1:0]       write_addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   new_data_q, data_d;
  logic                    init_done_q, init_done_d;

`ifdef REGFILE_INIT_CLEAR_EN
  logic [ADDR_W-1:0]       cnt_q, cnt_d;
`endif

  // Round-robin scan starting at the pointer; first valid requester wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    idx_p  = '0;
    for (int unsigned k = 0; k < NUM_WB_PORTS; k++) begin
      idx   = (32'(ptr_q) + k) % NUM_WB_PORTS;
      idx_p = PTR_W'(idx);
      if (!found && wb.wb_valid[idx_p]) begin
        found  = 1'b1;
        winner = idx_p;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    commit_d = 1'b0;
    addr_d   = write_addr_q;
    data_d   = new_data_q;
    ack_c    = '0;
`ifdef REGFILE_INIT_CLEAR_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ST_INIT: begin
`ifdef REGFILE_INIT_CLEAR_EN
        commit_d = 1'b1;
        addr_d   = cnt_q;
        data_d   = '0;
        cnt_d    = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
`else
        state_d = ST_RUN;
`endif
      end
      ST_RUN: begin
        // Grants wait for init_done so the first ack follows the enable edge.
        if (rst && init_done_q && found) begin
          ack_c[winner] = 1'b1;
          ptr_d    = (32'(winner) == NUM_WB_PORTS - 1) ? '0 : winner + PTR_W'(1);
          commit_d = (wb.wb_addr[winner] != '0);
          addr_d   = wb.wb_addr[winner];
          data_d   = wb.wb_data[winner];
        end
      end
    endcase
    init_done_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RESET_STATE;
      ptr_q        <= '0;
      commit_q     <= 1'b0;
      write_addr_q <= '0;
      new_data_q   <= '0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      commit_q     <= commit_d;
      write_addr_q <= addr_d;
      new_data_q   <= data_d;
      init_done_q  <= init_done_d;
    end
  end

`ifdef REGFILE_INIT_CLEAR_EN
  // Sweep starts at 1: register 0 is hardwired and never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= ADDR_W'(1);
    else      cnt_q <= cnt_d;
  end
`endif

  assign wb.wb_ack  = ack_c;
  assign write_addr = write_addr_q;
  assign new_data   = new_data_q;
  assign commit     = commit_q;
  assign init_done  = init_done_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (3 ports, 32-bit, 64 regs);
// covers both builds of REGFILE_INIT_CLEAR_EN.
module tb_regfile_write_arbiter;

  localparam int N     = 3;
  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk;
  logic          rst;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] new_data;
  logic          commit;
  logic          init_done;

  int passed = 0;
  int total  = 0;

  regfile_write_arbiter_if #(.NUM_WB_PORTS(N), .DATA_WIDTH(DW), .ADDR_W(AW)) wb_if ();

  regfile_write_arbiter #(
    .NUM_WB_PORTS(N), .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_W(AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wb         (wb_if),
    .write_addr (write_addr),
    .new_data   (new_data),
    .commit     (commit),
    .init_done  (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0;
    wb_if.wb_valid = 3'b111;
    wb_if.wb_addr  = {6'd3, 6'd2, 6'd1};
    wb_if.wb_data  = {32'h3, 32'h2, 32'h1};
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({commit, write_addr, new_data, init_done} !== {1'b0, 6'd0, 32'd0, 1'b0})
      $display("FAIL reset_outputs: got commit=%b addr=%0d data=%h done=%b, want 0/0/0/0",
               commit, write_addr, new_data, init_done);
    else passed++;
    total++;
    if (wb_if.wb_ack !== 3'b000)
      $display("FAIL reset_ack: got %b want 000", wb_if.wb_ack);
    else passed++;
  endtask

`ifdef REGFILE_INIT_CLEAR_EN
  task automatic test_sweep();
    wb_if.wb_valid = 3'b111;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      #1;
      total++;
      if (wb_if.wb_ack !== 3'b000)
        $display("FAIL sweep_ack[%0d]: got %b want 000", i, wb_if.wb_ack);
      else passed++;
      @(negedge clk);
      total++;
      if ({commit, write_addr, new_data, init_done} !== {1'b1, AW'(i), 32'd0, (i == DEPTH - 1)})
        $display("FAIL sweep_write[%0d]: got commit=%b addr=%0d data=%h done=%b, want 1/%0d/0/%b",
                 i, commit, write_addr, new_data, init_done, i, (i == DEPTH - 1));
      else passed++;
    end
    wb_if.wb_valid = 3'b000;
    @(negedge clk);
    total++;
    if ({commit, init_done} !== 2'b01)
      $display("FAIL sweep_end: got commit=%b done=%b want 0/1", commit, init_done);
    else passed++;
  endtask

  task automatic test_reset_mid_sweep();
    wb_if.wb_valid = 3'b111;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    total++;
    if ({commit, write_addr} !== {1'b1, 6'd20})
      $display("FAIL midsweep_pos: got commit=%b addr=%0d want 1/20", commit, write_addr);
    else passed++;
    rst = 1'b0;
    #1;
    total++;
    if ({commit, write_addr, new_data, init_done, wb_if.wb_ack} !== {1'b0, 6'd0, 32'd0, 1'b0, 3'b000})
      $display("FAIL midsweep_async: got commit=%b addr=%0d data=%h done=%b ack=%b, want all 0",
               commit, write_addr, new_data, init_done, wb_if.wb_ack);
    else passed++;
    repeat (2) @(negedge clk);
    total++;
    if ({commit, write_addr, new_data, init_done, wb_if.wb_ack} !== {1'b0, 6'd0, 32'd0, 1'b0, 3'b000})
      $display("FAIL midsweep_held: got commit=%b addr=%0d data=%h done=%b ack=%b, want all 0",
               commit, write_addr, new_data, init_done, wb_if.wb_ack);
    else passed++;
  endtask
`else
  task automatic test_first_cycle();
    wb_if.wb_valid = 3'b001;
    wb_if.wb_addr  = {6'd9, 6'd8, 6'd7};
    wb_if.wb_data  = {32'h99, 32'h88, 32'h77};
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({init_done, wb_if.wb_ack} !== 4'b0000)
      $display("FAIL first_before_edge: got done=%b ack=%b want 0/000", init_done, wb_if.wb_ack);
    else passed++;
    @(negedge clk);
    total++;
    if ({init_done, wb_if.wb_ack, commit} !== 5'b1_001_0)
      $display("FAIL first_grant: got done=%b ack=%b commit=%b want 1/001/0",
               init_done, wb_if.wb_ack, commit);
    else passed++;
    @(negedge clk);
    wb_if.wb_valid = 3'b000;
    total++;
    if ({commit, write_addr, new_data} !== {1'b1, 6'd7, 32'h77})
      $display("FAIL first_commit: got commit=%b addr=%0d data=%h want 1/7/77",
               commit, write_addr, new_data);
    else passed++;
  endtask

  task automatic test_ptr_after_reset();
    wb_if.wb_valid = 3'b011;
    wb_if.wb_addr  = {6'd32, 6'd31, 6'd30};
    wb_if.wb_data  = {32'h32, 32'h31, 32'h30};
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (wb_if.wb_ack !== 3'b001)
      $display("FAIL ptr_reset_grant: got %b want 001", wb_if.wb_ack);
    else passed++;
    @(negedge clk);
    total++;
    if ({commit, write_addr, new_data, wb_if.wb_ack} !== {1'b1, 6'd30, 32'h30, 3'b010})
      $display("FAIL ptr_reset_next: got commit=%b addr=%0d data=%h ack=%b want 1/30/30/010",
               commit, write_addr, new_data, wb_if.wb_ack);
    else passed++;
    wb_if.wb_valid = 3'b000;
    @(negedge clk);
  endtask
`endif

  // start_ack: one-hot of the requester the pointer currently favours.
  task automatic test_contention(input logic [2:0] start_ack);
    logic [2:0]    exp_ack;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    exp_ack = start_ack;
    wb_if.wb_addr  = {6'd12, 6'd11, 6'd10};
    wb_if.wb_data  = {32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
    wb_if.wb_valid = 3'b111;
    for (int c = 0; c < 9; c++) begin
      case (exp_ack)
        3'b001:  begin exp_addr = 6'd10; exp_data = 32'hC0DE_0000; end
        3'b010:  begin exp_addr = 6'd11; exp_data = 32'hC0DE_0001; end
        default: begin exp_addr = 6'd12; exp_data = 32'hC0DE_0002; end
      endcase
      #1;
      total++;
      if (wb_if.wb_ack !== exp_ack)
        $display("FAIL contention_ack[%0d]: got %b want %b", c, wb_if.wb_ack, exp_ack);
      else passed++;
      @(negedge clk);
      total++;
      if ({commit, write_addr, new_data} !== {1'b1, exp_addr, exp_data})
        $display("FAIL contention_commit[%0d]: got commit=%b addr=%0d data=%h want 1/%0d/%h",
                 c, commit, write_addr, new_data, exp_addr, exp_data);
      else passed++;
      exp_ack = {exp_ack[1:0], exp_ack[2]};
    end
    wb_if.wb_valid = 3'b000;
    @(negedge clk);
    total++;
    if (commit !== 1'b0)
      $display("FAIL contention_idle: got commit=%b want 0", commit);
    else passed++;
  endtask

  task automatic test_single();
    wb_if.wb_addr  = {6'd33, 6'd5, 6'd44};
    wb_if.wb_data  = {32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};
    wb_if.wb_valid = 3'b010;
    #1;
    total++;
    if (wb_if.wb_ack !== 3'b010)
      $display("FAIL single_ack: got %b want 010", wb_if.wb_ack);
    else passed++;
    @(negedge clk);
    wb_if.wb_valid = 3'b000;
    total++;
    if ({commit, write_addr, new_data} !== {1'b1, 6'd5, 32'hDEAD_BEEF})
      $display("FAIL single_commit: got commit=%b addr=%0d data=%h want 1/5/deadbeef",
               commit, write_addr, new_data);
    else passed++;
  endtask

  task automatic test_zero_drop();
    wb_if.wb_addr  = {6'd0, 6'd17, 6'd18};
    wb_if.wb_data  = {32'h0000_1234, 32'h17, 32'h18};
    wb_if.wb_valid = 3'b100;
    #1;
    total++;
    if (wb_if.wb_ack !== 3'b100)
      $display("FAIL zero_ack: got %b want 100", wb_if.wb_ack);
    else passed++;
    @(negedge clk);
    wb_if.wb_valid = 3'b000;
    total++;
    if (commit !== 1'b0)
      $display("FAIL zero_commit: got commit=%b addr=%0d want commit 0", commit, write_addr);
    else passed++;
  endtask

  task automatic test_partial();
    logic [2:0]    exp_ack [3] = '{3'b001, 3'b100, 3'b001};
    logic [AW-1:0] exp_addr[3] = '{6'd20, 6'd22, 6'd20};
    wb_if.wb_addr  = {6'd22, 6'd21, 6'd20};
    wb_if.wb_data  = {32'hAAAA_0022, 32'hAAAA_0021, 32'hAAAA_0020};
    wb_if.wb_valid = 3'b101;
    foreach (exp_ack[s]) begin
      #1;
      total++;
      if (wb_if.wb_ack !== exp_ack[s])
        $display("FAIL partial_ack[%0d]: got %b want %b", s, wb_if.wb_ack, exp_ack[s]);
      else passed++;
      @(negedge clk);
      total++;
      if ({commit, write_addr} !== {1'b1, exp_addr[s]})
        $display("FAIL partial_commit[%0d]: got commit=%b addr=%0d want 1/%0d",
                 s, commit, write_addr, exp_addr[s]);
      else passed++;
    end
    wb_if.wb_valid = 3'b000;
    @(negedge clk);
  endtask

  task automatic test_in_flight();
    wb_if.wb_addr  = {6'd50, 6'd40, 6'd9};
    wb_if.wb_data  = {32'h50, 32'h40, 32'h99};
    wb_if.wb_valid = 3'b001;
    #1;
    total++;
    if (wb_if.wb_ack !== 3'b001)
      $display("FAIL inflight_ack: got %b want 001", wb_if.wb_ack);
    else passed++;
    @(negedge clk);
    wb_if.wb_valid = 3'b000;
    total++;
    if ({commit, write_addr} !== {1'b1, 6'd9})
      $display("FAIL inflight_commit: got commit=%b addr=%0d want 1/9", commit, write_addr);
    else passed++;
    rst = 1'b0;
    #1;
    total++;
    if ({commit, write_addr, new_data, init_done} !== {1'b0, 6'd0, 32'd0, 1'b0})
      $display("FAIL inflight_discard: got commit=%b addr=%0d data=%h done=%b want 0/0/0/0",
               commit, write_addr, new_data, init_done);
    else passed++;
  endtask

  initial begin
    rst = 1'b0;
    wb_if.wb_valid = '0;
    wb_if.wb_addr  = '0;
    wb_if.wb_data  = '0;
    test_reset();
`ifdef REGFILE_INIT_CLEAR_EN
    test_sweep();
    test_contention(3'b001);
    test_single();
    test_zero_drop();
    test_partial();
    test_in_flight();
    test_sweep();
    test_reset_mid_sweep();
    test_sweep();
`else
    test_first_cycle();
    test_contention(3'b010);
    test_single();
    test_zero_drop();
    test_partial();
    test_in_flight();
    test_ptr_after_reset();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
